pwm_duty_capture: RTL

Three-channel PWM receiver that recovers the duty cycle and period of the RGB_R/RGB_G/RGB_B waveforms produced by the PWM LED driver.
It sits beside the driver, in simulation loopback or on-chip, for self-checking and closed-loop colour monitoring.
Each channel independently synchronises its input, detects rising edges, counts high cycles per period and reports one result per period, with a timeout for constant-level inputs.

---
 rtl/pwm_duty_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: three-channel PWM receiver.
// Each channel synchronises its asynchronous input and finds rising edges.
// It counts the period and the high cycles between consecutive rises and
// reports one duty/period pair per input period. A timeout report flags an
// input that has stopped toggling.
//
// Output strobe semantics (valid only, no ready):
//   valid_x is high for exactly one clk cycle whenever duty_x/period_x take a
//   new value. There is no back-pressure. duty_x/period_x hold their last
//   value until the next strobe. The consumer must capture them while
//   valid_x is high.
//
// Channel index map used throughout: 0 = red, 1 = green, 2 = blue.
module pwm_duty_capture #(
  parameter int PWM_INTERVAL = 1200,
  parameter int DW           = $clog2(PWM_INTERVAL + 1),
  parameter int PW           = $clog2(2 * PWM_INTERVAL + 1),
  parameter int TIMEOUT      = 2 * PWM_INTERVAL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_r,
  input  logic          pwm_g,
  input  logic          pwm_b,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [PW-1:0] period_r,
  output logic [PW-1:0] period_g,
  output logic [PW-1:0] period_b,
  output logic          valid_r,
  output logic          valid_g,
  output logic          valid_b
);

  // WAIT_EDGE: no phase reference yet (after reset or after a timeout).
  // MEASURE:   the previous rise is known, so the next rise closes a period.
  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } chan_state_e;

  localparam int NCH = 3;

  localparam logic [PW-1:0] CNT_MAX   = {PW{1'b1}};
  localparam logic [PW-1:0] ONE_C     = PW'(1);
  localparam logic [PW-1:0] TIMEOUT_C = PW'(TIMEOUT);
  localparam logic [PW-1:0] FULL_P    = PW'(PWM_INTERVAL);
  localparam logic [DW-1:0] FULL_D    = DW'(PWM_INTERVAL);

  logic [NCH-1:0] pwm_in;

  // Three-stage sampling chain: sync1 -> sync2 form the synchroniser.
  // prev holds the previous synchronised level for edge detection.
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] prev;
  logic [NCH-1:0] rise;

  // Per-channel FSM state. The array stays visible so checkers can bind to it.
  chan_state_e    state [NCH];

  logic [PW-1:0]  period_cnt [NCH];
  logic [PW-1:0]  high_cnt   [NCH];

  // Registered result outputs.
  logic [DW-1:0]  duty_q   [NCH];
  logic [PW-1:0]  period_q [NCH];
  logic [NCH-1:0] valid_q;

  // Next-value helpers, computed combinationally.
  logic [PW-1:0]  period_inc   [NCH];
  logic [PW-1:0]  high_inc     [NCH];
  logic [DW-1:0]  duty_clamped [NCH];
  logic [NCH-1:0] timeout_hit;

  assign pwm_in = {pwm_b, pwm_g, pwm_r};

  // Double-flop synchroniser plus one delayed copy for rise detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A rise is a low-to-high step of the synchronised level.
  assign rise = sync2 & ~prev;

  // Build saturating increments, detect the timeout and clamp the duty.
  // The timeout fires when the next period count would reach TIMEOUT.
  // A constant-level input therefore reports once every TIMEOUT cycles.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      period_inc[i] = (period_cnt[i] == CNT_MAX) ? CNT_MAX : period_cnt[i] + ONE_C;

      if (sync2[i]) begin
        high_inc[i] = (high_cnt[i] == CNT_MAX) ? CNT_MAX : high_cnt[i] + ONE_C;
      end else begin
        high_inc[i] = high_cnt[i];
      end

      timeout_hit[i] = (period_inc[i] >= TIMEOUT_C);

      if (high_cnt[i] > FULL_P) begin
        duty_clamped[i] = FULL_D;
      end else begin
        duty_clamped[i] = high_cnt[i][DW-1:0];
      end
    end
  end

  // Per-channel measurement FSM. It owns the counters and the registered outputs.
  // A rise takes priority over a timeout in the same cycle. The first rise
  // after WAIT_EDGE only sets the phase reference and gives no report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]      <= WAIT_EDGE;
        period_cnt[i] <= '0;
        high_cnt[i]   <= '0;
        duty_q[i]     <= '0;
        period_q[i]   <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        valid_q[i] <= 1'b0;

        if (rise[i]) begin
          if (state[i] == MEASURE) begin
            duty_q[i]   <= duty_clamped[i];
            period_q[i] <= period_cnt[i];
            valid_q[i]  <= 1'b1;
          end
          // The rise cycle itself is high, so it opens the new period at 1/1.
          state[i]      <= MEASURE;
          period_cnt[i] <= ONE_C;
          high_cnt[i]   <= ONE_C;
        end else if (timeout_hit[i]) begin
          duty_q[i]     <= sync2[i] ? FULL_D : '0;
          period_q[i]   <= '0;
          valid_q[i]    <= 1'b1;
          period_cnt[i] <= '0;
          high_cnt[i]   <= '0;
          state[i]      <= WAIT_EDGE;
        end else begin
          period_cnt[i] <= period_inc[i];
          high_cnt[i]   <= high_inc[i];
        end
      end
    end
  end

  assign duty_r   = duty_q[0];
  assign duty_g   = duty_q[1];
  assign duty_b   = duty_q[2];
  assign period_r = period_q[0];
  assign period_g = period_q[1];
  assign period_b = period_q[2];
  assign valid_r  = valid_q[0];
  assign valid_g  = valid_q[1];
  assign valid_b  = valid_q[2];

endmodule
